// File: rtl/aes_mask_pkg.sv
// Shared constants and lane-slice helpers for factor-form (sum, hi, lo) GF(4) shares.
package aes_mask_pkg;
   localparam int FAC_W         = 3;
   localparam int GF4_W         = 2;
   localparam int ERR_CNT_W_DEF = 8;

   function automatic logic fac_sum(input logic [FAC_W-1:0] t);
      return t[2];
   endfunction

   function automatic logic fac_hi(input logic [FAC_W-1:0] t);
      return t[1];
   endfunction

   function automatic logic fac_lo(input logic [FAC_W-1:0] t);
      return t[0];
   endfunction
endpackage

// File: rtl/fac_2_unpack_if.sv
// Input/output stream bus plus error-status signals of the factor unpacker.
interface fac_2_unpack_if #(
   parameter int LANES = 4,
   parameter int CNT_W = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [3*LANES-1:0]   in_q;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*LANES-1:0]   out_a;
   logic [LANES-1:0]     out_err;
   logic [CNT_W-1:0]     err_cnt;
   logic                 err_sticky;
   logic                 clr;

   modport master (
      output in_valid, in_q, out_ready, clr,
      input  in_ready, out_valid, out_a, out_err, err_cnt, err_sticky
   );

   modport slave (
      input  in_valid, in_q, out_ready, clr,
      output in_ready, out_valid, out_a, out_err, err_cnt, err_sticky
   );
endinterface

// File: rtl/fac_2_unpack_chk.sv
// One lane: recovers {hi, lo} from a factor triple and flags sum != hi ^ lo.
module fac_2_chk
   import aes_mask_pkg::*;
(
   input  logic [FAC_W-1:0] fac_i,
   output logic [GF4_W-1:0] val_o,
   output logic             err_o
);
   assign val_o = {fac_hi(fac_i), fac_lo(fac_i)};
   assign err_o = fac_sum(fac_i) ^ fac_hi(fac_i) ^ fac_lo(fac_i);
endmodule

// File: rtl/fac_2_unpack.sv
// Streaming factor-triple to GF(4) unpacker: one output register stage with
// valid/ready handshake, per-lane consistency check and saturating error count.
module fac_2_unpack
   import aes_mask_pkg::*;
#(
   parameter int LANES    = 4,
   parameter int CNT_W    = ERR_CNT_W_DEF,
   parameter int DROP_ERR = 0
) (
   input logic              clk,
   input logic              rst_n,
   fac_2_unpack_if.slave    bus
);
   logic [GF4_W*LANES-1:0] lane_val;
   logic [LANES-1:0]       lane_err;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         fac_2_chk u_chk (
            .fac_i (bus.in_q[FAC_W*gi +: FAC_W]),
            .val_o (lane_val[GF4_W*gi +: GF4_W]),
            .err_o (lane_err[gi])
         );
      end
   endgenerate

   logic                   valid_q, valid_d;
   logic [GF4_W*LANES-1:0] a_q, a_d;
   logic [LANES-1:0]       err_q, err_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   sticky_q, sticky_d;

   logic in_ready;
   logic accept;
   logic any_err;
   logic load;

   assign in_ready = !valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;
   // lane_err only matters under accept, so in_q garbage while idle never counts
   assign any_err  = |lane_err;
   assign load     = accept && !((DROP_ERR != 0) && any_err);

   always_comb begin
      valid_d = valid_q;
      a_d     = a_q;
      err_d   = err_q;
      if (load) begin
         valid_d = 1'b1;
         a_d     = lane_val;
         err_d   = lane_err;
      end else if (accept) begin
         valid_d = 1'b0;
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Clear is applied before the current beat is counted.
   always_comb begin
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      if (bus.clr) begin
         cnt_d    = '0;
         sticky_d = 1'b0;
      end
      if (accept && any_err) begin
         sticky_d = 1'b1;
         if (cnt_d != {CNT_W{1'b1}}) begin
            cnt_d = cnt_d + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         a_q      <= '0;
         err_q    <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         a_q      <= a_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = valid_q;
   assign bus.out_a      = a_q;
   assign bus.out_err    = err_q;
   assign bus.err_cnt    = cnt_q;
   assign bus.err_sticky = sticky_q;
endmodule

// File: tb/tb_fac_2_unpack.sv
// Bench for fac_2_unpack: three instances (pass-through, drop-on-error, 2-bit counter)
// share one random stimulus and are compared each cycle against a queue-based model.
module tb_fac_2_unpack;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [11:0] in_q = '0;
   logic        out_ready = 1'b0;
   logic        clr = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fac_2_unpack_if #(.LANES(4), .CNT_W(8)) if_m ();
   fac_2_unpack_if #(.LANES(4), .CNT_W(8)) if_d ();
   fac_2_unpack_if #(.LANES(4), .CNT_W(2)) if_s ();

   fac_2_unpack #(.LANES(4), .CNT_W(8), .DROP_ERR(0)) u_main (.clk(clk), .rst_n(rst_n), .bus(if_m.slave));
   fac_2_unpack #(.LANES(4), .CNT_W(8), .DROP_ERR(1)) u_drop (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));
   fac_2_unpack #(.LANES(4), .CNT_W(2), .DROP_ERR(0)) u_sat  (.clk(clk), .rst_n(rst_n), .bus(if_s.slave));

   assign if_m.in_valid = in_valid;  assign if_m.in_q = in_q;  assign if_m.out_ready = out_ready;  assign if_m.clr = clr;
   assign if_d.in_valid = in_valid;  assign if_d.in_q = in_q;  assign if_d.out_ready = out_ready;  assign if_d.clr = clr;
   assign if_s.in_valid = in_valid;  assign if_s.in_q = in_q;  assign if_s.out_ready = out_ready;  assign if_s.clr = clr;

   logic       dv [3];
   logic       dr [3];
   logic [7:0] da [3];
   logic [3:0] de [3];
   logic [7:0] dc [3];
   logic       ds [3];

   assign dv[0] = if_m.out_valid; assign dv[1] = if_d.out_valid; assign dv[2] = if_s.out_valid;
   assign dr[0] = if_m.in_ready;  assign dr[1] = if_d.in_ready;  assign dr[2] = if_s.in_ready;
   assign da[0] = if_m.out_a;     assign da[1] = if_d.out_a;     assign da[2] = if_s.out_a;
   assign de[0] = if_m.out_err;   assign de[1] = if_d.out_err;   assign de[2] = if_s.out_err;
   assign dc[0] = if_m.err_cnt;   assign dc[1] = if_d.err_cnt;   assign dc[2] = {6'b0, if_s.err_cnt};
   assign ds[0] = if_m.err_sticky; assign ds[1] = if_d.err_sticky; assign ds[2] = if_s.err_sticky;

   // Model: beats waiting to be presented ({a, err}), errors counted since last clear.
   logic [11:0] exp_q [3][$];
   int          errs [3];
   int          cnt_max [3] = '{255, 255, 3};
   bit          drops [3]   = '{1'b0, 1'b1, 1'b0};

   function automatic logic [7:0] ref_a(input logic [11:0] t);
      logic [7:0] r;
      for (int l = 0; l < 4; l++) r[2*l +: 2] = t[3*l +: 2];
      return r;
   endfunction

   function automatic logic [3:0] ref_err(input logic [11:0] t);
      logic [3:0] r;
      for (int l = 0; l < 4; l++) r[l] = (t[3*l+2] != (t[3*l+1] ^ t[3*l]));
      return r;
   endfunction

   function automatic logic [11:0] gen(input bit make_err);
      logic [11:0] t;
      for (int l = 0; l < 4; l++) begin
         t[3*l +: 2] = 2'($urandom_range(0, 3));
         t[3*l+2]    = t[3*l+1] ^ t[3*l];
      end
      if (make_err) t[3*$urandom_range(0, 3) + 2] ^= 1'b1;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         exp_q[k].delete();
         errs[k] = 0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         bit acc;
         logic [3:0] e;
         acc = in_valid && (exp_q[k].size() == 0 || out_ready);
         e   = ref_err(in_q);
         if (exp_q[k].size() != 0 && out_ready) void'(exp_q[k].pop_front());
         if (acc && !(drops[k] && e != 4'h0)) exp_q[k].push_back({ref_a(in_q), e});
         if (clr) errs[k] = 0;
         if (acc && e != 4'h0) errs[k]++;
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 3; k++) begin
         int c;
         c = (errs[k] > cnt_max[k]) ? cnt_max[k] : errs[k];
         chk($sformatf("out_valid[%0d]", k), 32'(dv[k]), 32'(exp_q[k].size() != 0));
         if (exp_q[k].size() != 0) begin
            chk($sformatf("out_a[%0d]", k), 32'(da[k]), 32'(exp_q[k][0][11:4]));
            chk($sformatf("out_err[%0d]", k), 32'(de[k]), 32'(exp_q[k][0][3:0]));
         end
         chk($sformatf("err_cnt[%0d]", k), 32'(dc[k]), 32'(c));
         chk($sformatf("err_sticky[%0d]", k), 32'(ds[k]), 32'(errs[k] > 0));
      end
   endtask

   // Called just after a falling edge: drive, check in_ready, advance model, check outputs.
   task automatic step(input logic v, input logic [11:0] d, input logic r, input logic c);
      in_valid  = v;
      in_q      = d;
      out_ready = r;
      clr       = c;
      #1;
      for (int k = 0; k < 3; k++)
         chk($sformatf("in_ready[%0d]", k), 32'(dr[k]), 32'(exp_q[k].size() == 0 || out_ready));
      model_edge();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      int accepted;
      int budget;
      logic [7:0] errset;
      int sat_seq [5] = '{1, 2, 3, 3, 3};

      model_reset();
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst out_valid[%0d]", k), 32'(dv[k]), 32'h0);
         chk($sformatf("rst out_a[%0d]", k), 32'(da[k]), 32'h0);
         chk($sformatf("rst out_err[%0d]", k), 32'(de[k]), 32'h0);
         chk($sformatf("rst err_cnt[%0d]", k), 32'(dc[k]), 32'h0);
         chk($sformatf("rst err_sticky[%0d]", k), 32'(ds[k]), 32'h0);
         chk($sformatf("rst in_ready[%0d]", k), 32'(dr[k]), 32'h1);
      end
      rst_n = 1'b1;

      // Hand-computed pins for the model.
      step(1'b1, 12'hCE8, 1'b1, 1'b0);
      chk("pin CE8 out_valid", 32'(dv[0]), 32'h1);
      chk("pin CE8 out_a", 32'(da[0]), 32'hB4);
      chk("pin CE8 out_err", 32'(de[0]), 32'h0);
      chk("pin CE8 err_cnt", 32'(dc[0]), 32'h0);
      step(1'b1, 12'hCEC, 1'b1, 1'b0);
      chk("pin CEC out_a", 32'(da[0]), 32'hB4);
      chk("pin CEC out_err", 32'(de[0]), 32'h1);
      chk("pin CEC err_cnt", 32'(dc[0]), 32'h1);
      chk("pin CEC err_sticky", 32'(ds[0]), 32'h1);
      chk("pin CEC drop out_valid", 32'(dv[1]), 32'h0);
      chk("pin CEC drop err_cnt", 32'(dc[1]), 32'h1);

      // Backpressure with a clean beat held on the input.
      step(1'b1, gen(1'b0), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, gen(1'b0), 1'b0, 1'b0);
         chk("hold in_ready", 32'(dr[0]), 32'h0);
      end

      // 16 accepted beats under random valid/ready, mixed error beats.
      accepted = 0;
      budget   = 0;
      while (accepted < 16 && budget < 400) begin
         logic v;
         logic r;
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 3) != 0);
         if (v && (exp_q[0].size() == 0 || r)) accepted++;
         step(v, v ? gen($urandom_range(0, 3) == 0) : 12'($urandom), r, 1'b0);
         budget++;
      end
      chk("random beats accepted", 32'(accepted), 32'd16);
      step(1'b0, 12'h0, 1'b1, 1'b0);
      chk("drained out_valid", 32'(dv[0]), 32'h0);

      // Saturation of the 2-bit counter, then clear together with an error beat.
      step(1'b0, 12'h0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, gen(1'b1), 1'b1, 1'b0);
         chk($sformatf("sat err_cnt #%0d", i), 32'(dc[2]), 32'(sat_seq[i]));
      end
      step(1'b1, gen(1'b1), 1'b1, 1'b1);
      chk("clr+err sat err_cnt", 32'(dc[2]), 32'h1);
      chk("clr+err main err_cnt", 32'(dc[0]), 32'h1);

      // Every lane-0 triple: inconsistent exactly for 001, 010, 100, 111.
      errset = 8'b1001_0110;
      for (int t = 0; t < 8; t++) begin
         step(1'b1, 12'(t), 1'b1, 1'b0);
         chk($sformatf("lane0 err t=%0d", t), 32'(de[0][0]), 32'(errset[t]));
         chk($sformatf("lane0 a t=%0d", t), 32'(da[0][1:0]), 32'(t % 4));
      end

      // Asynchronous reset while a beat is stalled on the output.
      step(1'b1, gen(1'b0), 1'b1, 1'b0);
      step(1'b1, gen(1'b0), 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("async rst out_valid[%0d]", k), 32'(dv[k]), 32'h0);
         chk($sformatf("async rst err_cnt[%0d]", k), 32'(dc[k]), 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post rst in_ready", 32'(dr[0]), 32'h1);
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         logic v;
         v = ($urandom_range(0, 1) != 0);
         step(v, gen($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
